// File: rtl/svc_rv_mem_pkg.sv
// Shared types and constants for the BRAM arbiter slice.
package svc_rv_mem_pkg;

  // Data and address widths the request struct is built for.
  localparam int MEM_XLEN = 32;
  localparam int MEM_AW   = 10;
  localparam int MEM_SW   = MEM_XLEN / 8;

  // Requester indices.
  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  // One memory request as seen by the BRAM.
  typedef struct packed {
    logic                we;
    logic [MEM_AW-1:0]   addr;
    logic [MEM_XLEN-1:0] wdata;
    logic [MEM_SW-1:0]   wstrb;
  } mem_req_t;

endpackage

// File: rtl/svc_rv_bram_arb_if.sv
// Two-requester request/response bus plus the BRAM-facing signals.
interface svc_rv_bram_arb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 10
);
  localparam int SW = XLEN / 8;

  // Requester side, one lane per port.
  logic [1:0]           p_valid;
  logic [1:0]           p_ready;
  logic [1:0]           p_we;
  logic [1:0][AW-1:0]   p_addr;
  logic [1:0][XLEN-1:0] p_wdata;
  logic [1:0][SW-1:0]   p_wstrb;
  logic [1:0]           p_rvalid;
  logic [XLEN-1:0]      p_rdata;

  // BRAM side.
  logic                 mem_en;
  logic [SW-1:0]        mem_wstrb;
  logic [AW-1:0]        mem_addr;
  logic [XLEN-1:0]      mem_wdata;
  logic [XLEN-1:0]      mem_rdata;

  // The arbiter.
  modport slave (
    input  p_valid, p_we, p_addr, p_wdata, p_wstrb, mem_rdata,
    output p_ready, p_rvalid, p_rdata, mem_en, mem_wstrb, mem_addr, mem_wdata
  );

  // The environment: requesters plus the BRAM macro.
  modport master (
    output p_valid, p_we, p_addr, p_wdata, p_wstrb, mem_rdata,
    input  p_ready, p_rvalid, p_rdata, mem_en, mem_wstrb, mem_addr, mem_wdata
  );

endinterface

// File: rtl/svc_arb_rr2.sv
// Two-way grant logic: fixed CPU priority with a starvation escape, or round-robin.
module svc_arb_rr2 #(
  parameter int CPU_PRIO   = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  logic [SW-1:0] starve_cnt_reg;
  logic [SW-1:0] starve_cnt_next;
  logic          last_gnt_reg;   // 1 = port 1 won the last contested cycle
  logic          last_gnt_next;
  logic          starved;

  // Grant selection and next arbiter state; no grant at all while in reset.
  always_comb begin
    gnt             = 2'b00;
    starve_cnt_next = starve_cnt_reg;
    last_gnt_next   = last_gnt_reg;
    starved         = (starve_cnt_reg == SW'(MAX_STARVE));

    if (!rst) begin
      if (CPU_PRIO != 0) begin
        if (req[1] && starved)  gnt = 2'b10;
        else if (req[0])        gnt = 2'b01;
        else if (req[1])        gnt = 2'b10;
      end else begin
        if (req == 2'b11)       gnt = last_gnt_reg ? 2'b01 : 2'b10;
        else                    gnt = req;
      end
    end

    // Count consecutive lost cycles of port 1, saturating at the limit.
    if (req[1] && !gnt[1]) begin
      if (!starved) starve_cnt_next = starve_cnt_reg + SW'(1);
    end else begin
      starve_cnt_next = '0;
    end

    // Only a contested grant moves the round-robin pointer.
    if (req == 2'b11 && gnt != 2'b00) last_gnt_next = gnt[1];
  end

  // Arbiter state; port 1 is "last" after reset so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
      last_gnt_reg   <= 1'b1;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      last_gnt_reg   <= last_gnt_next;
    end
  end

endmodule

// File: rtl/svc_rv_bram_arb.sv
// Shares one single-port BRAM between the core data port and a debug master.
module svc_rv_bram_arb
  import svc_rv_mem_pkg::*;
#(
  parameter int XLEN       = MEM_XLEN,
  parameter int AW         = MEM_AW,
  parameter int CPU_PRIO   = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  svc_rv_bram_arb_if.slave  bus
);

  // The request struct is sized from the package; other widths are rejected.
  if (XLEN != MEM_XLEN || AW != MEM_AW) begin : g_width_check
    $error("svc_rv_bram_arb: XLEN/AW must match svc_rv_mem_pkg");
  end

  logic [1:0] gnt;
  logic       win_port;
  mem_req_t   port_req [2];
  mem_req_t   win_req;
  logic       pending_reg;  // a read was accepted last cycle
  logic       owner_reg;    // port that owns the in-flight read

  svc_arb_rr2 #(
    .CPU_PRIO   (CPU_PRIO),
    .MAX_STARVE (MAX_STARVE)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.p_valid),
    .gnt (gnt)
  );

  // Gather each port's fields into a request record.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign port_req[gi] = '{
      we:    bus.p_we[gi],
      addr:  bus.p_addr[gi],
      wdata: bus.p_wdata[gi],
      wstrb: bus.p_wstrb[gi]
    };
    assign bus.p_rvalid[gi] = pending_reg & ~rst & (owner_reg == 1'(gi));
  end

  // Route the winner's request to the BRAM.
  always_comb begin
    win_port = gnt[PORT_DBG];
    win_req  = port_req[win_port];
  end

  assign bus.p_ready   = gnt;
  assign bus.mem_en    = |gnt;
  assign bus.mem_addr  = win_req.addr;
  assign bus.mem_wdata = win_req.wdata;
  assign bus.mem_wstrb = (bus.mem_en && win_req.we) ? win_req.wstrb : '0;
  assign bus.p_rdata   = bus.mem_rdata;

  // Remember who owns the read in flight so its data returns to that port.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 1'b0;
      owner_reg   <= 1'(PORT_CPU);
    end else begin
      pending_reg <= bus.mem_en & ~win_req.we;
      owner_reg   <= win_port;
    end
  end

endmodule
